sram_frame_arbiter: RTL

SRAM_FRAME_ARBITER -- requirements
Module: sram_frame_arbiter

---
 rtl/sram_frame_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_frame_arbiter.sv
// Arbitrates a camera write stream and a display read port onto one asynchronous SRAM.
// Writes fill a frame-linear address counter; reads use the requester's address.
module sram_frame_arbiter #(
  parameter int unsigned FRAME_PIXELS = 153600,
  parameter int unsigned RD_WAIT      = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        W_Frame_Start,
  input  logic        W_Req,
  input  logic [7:0]  W_Data,
  output logic        W_Ack,
  output logic        W_Ovf,
  input  logic        R_Req,
  input  logic [17:0] R_Addr,
  output logic        R_Ack,
  output logic        R_Valid,
  output logic [7:0]  R_Data,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [7:0]  SRAM_DATA,
  output logic        SRAM_CE,
  output logic        SRAM_WE,
  output logic        SRAM_OE,
  output logic        SRAM_LB,
  output logic        SRAM_UB
);

  localparam int unsigned AW        = 18;
  localparam int unsigned DW        = 8;
  localparam int unsigned CW        = 19;
  localparam int unsigned WCW       = 3;
  localparam int unsigned WAIT_LAST = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD, ST_RD_ADDR, ST_RD_WAIT, ST_RD_SAMPLE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_base;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            ovf_q, ovf_d;
  logic            last_wr_q, last_wr_d;
  logic            w_ack_q, w_ack_d;
  logic            r_ack_q, r_ack_d;
  logic            r_valid_q, r_valid_d;
  logic            ce_q, ce_d, we_q, we_d, oe_q, oe_d, drv_q, drv_d;
  logic            w_pend, r_pend, grant_w, grant_r;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      last_wr_q <= 1'b0;
      w_ack_q   <= 1'b0;
      r_ack_q   <= 1'b0;
      r_valid_q <= 1'b0;
      ce_q      <= 1'b1;
      we_q      <= 1'b1;
      oe_q      <= 1'b1;
      drv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      ovf_q     <= ovf_d;
      last_wr_q <= last_wr_d;
      w_ack_q   <= w_ack_d;
      r_ack_q   <= r_ack_d;
      r_valid_q <= r_valid_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      drv_q     <= drv_d;
    end
  end

  // A request is not re-granted during its own Ack cycle; the requester is still holding it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    ovf_d     = ovf_q;
    last_wr_d = last_wr_q;
    w_ack_d   = 1'b0;
    r_ack_d   = 1'b0;
    r_valid_d = 1'b0;
    w_pend    = W_Req & ~w_ack_q;
    r_pend    = R_Req & ~r_ack_q;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    cnt_base  = W_Frame_Start ? '0 : cnt_q;
    cnt_d     = cnt_base;
    if (W_Frame_Start) ovf_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        grant_w = w_pend & (~r_pend | ~last_wr_q);
        grant_r = r_pend & ~grant_w;
        if (grant_w) begin
          w_ack_d   = 1'b1;
          last_wr_d = 1'b1;
          if (cnt_base >= CW'(FRAME_PIXELS)) begin
            ovf_d = 1'b1;
          end else begin
            state_d = ST_WR_SETUP;
            addr_d  = AW'(cnt_base);
            wdata_d = W_Data;
            cnt_d   = cnt_base + CW'(1);
          end
        end else if (grant_r) begin
          r_ack_d   = 1'b1;
          last_wr_d = 1'b0;
          addr_d    = R_Addr;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: state_d = ST_WR_HOLD;
      ST_WR_HOLD:  state_d = ST_IDLE;
      ST_RD_ADDR: begin
        wait_d  = '0;
        state_d = (RD_WAIT == 0) ? ST_RD_SAMPLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_q == WCW'(WAIT_LAST)) state_d = ST_RD_SAMPLE;
        else                           wait_d  = wait_q + WCW'(1);
      end
      ST_RD_SAMPLE: begin
        rdata_d   = SRAM_DATA;
        r_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with the registered state.
    ce_d  = (state_d == ST_IDLE);
    we_d  = (state_d != ST_WR_PULSE);
    oe_d  = !((state_d == ST_RD_ADDR) || (state_d == ST_RD_WAIT) || (state_d == ST_RD_SAMPLE));
    drv_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
  end

  assign SRAM_DATA = drv_q ? wdata_q : 'z;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE   = ce_q;
  assign SRAM_LB   = ce_q;
  assign SRAM_UB   = 1'b1;
  assign SRAM_WE   = we_q;
  assign SRAM_OE   = oe_q;
  assign W_Ack     = w_ack_q;
  assign W_Ovf     = ovf_q;
  assign R_Ack     = r_ack_q;
  assign R_Valid   = r_valid_q;
  assign R_Data    = rdata_q;

endmodule
